// File: rtl/riscv_defines.sv
// Shared RI5CY debug definitions: debug-master opcodes, debug-unit addresses
// and control-register bit values.
package riscv_defines;

   localparam logic [2:0]  DBGM_HALT   = 3'd0;
   localparam logic [2:0]  DBGM_RESUME = 3'd1;
   localparam logic [2:0]  DBGM_STEP   = 3'd2;
   localparam logic [2:0]  DBGM_READ   = 3'd3;
   localparam logic [2:0]  DBGM_WRITE  = 3'd4;

   localparam logic [14:0] DBG_ADDR_CTRL = 15'h0000;
   localparam logic [14:0] DBG_ADDR_NPC  = 15'h2000;
   localparam logic [14:0] DBG_ADDR_PPC  = 15'h2004;
   localparam logic [14:0] DBG_ADDR_GPR0 = 15'h0400;

   localparam logic [31:0] DBG_CTRL_HALT = 32'h0001_0000;
   localparam logic [31:0] DBG_CTRL_SSTE = 32'h0000_0001;

   function automatic logic dbgm_op_legal(input logic [2:0] op);
      return (op <= DBGM_WRITE);
   endfunction

endpackage

// File: rtl/riscv_debug_master.sv
// Host-side debug initiator: turns abstract debug commands into RI5CY debug-bus
// transactions and returns one response per command.
module riscv_debug_master
   import riscv_defines::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [2:0]  cmd_op_i,
   input  logic [14:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        debug_req_o,
   input  logic        debug_gnt_i,
   input  logic        debug_rvalid_i,
   output logic [14:0] debug_addr_o,
   output logic        debug_we_o,
   output logic [31:0] debug_wdata_o,
   input  logic [31:0] debug_rdata_i,
   input  logic        debug_halted_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RVAL,
      WAIT_RUN,
      WAIT_HALT,
      RSP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic               accept;
   logic               timed_out;
   logic               rsp_entry;
   logic               rsp_err_d;

   assign cmd_ready_o = (state_q == IDLE) && !rst;
   assign debug_req_o = (state_q == REQ);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign timed_out   = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign rsp_entry   = (state_d == RSP) && (state_q != RSP);

   always_comb begin
      state_d   = state_q;
      rsp_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!dbgm_op_legal(cmd_op_i) ||
                   (cmd_op_i == DBGM_STEP && !debug_halted_i)) begin
                  state_d   = RSP;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (debug_gnt_i) begin
               state_d = RVAL;
            end else if (timed_out) begin
               state_d   = RSP;
               rsp_err_d = 1'b1;
            end
         end
         RVAL: begin
            if (debug_rvalid_i) begin
               case (op_q)
                  DBGM_HALT:              state_d = WAIT_HALT;
                  DBGM_RESUME, DBGM_STEP: state_d = WAIT_RUN;
                  default:                state_d = RSP;
               endcase
            end else if (timed_out) begin
               state_d   = RSP;
               rsp_err_d = 1'b1;
            end
         end
         WAIT_RUN: begin
            if (!debug_halted_i) begin
               state_d = (op_q == DBGM_STEP) ? WAIT_HALT : RSP;
            end else if (timed_out) begin
               state_d   = RSP;
               rsp_err_d = 1'b1;
            end
         end
         WAIT_HALT: begin
            if (debug_halted_i) begin
               state_d = RSP;
            end else if (timed_out) begin
               state_d   = RSP;
               rsp_err_d = 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Counter restarts on every state change; it only runs in the waiting states.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q || state_q == IDLE || state_q == RSP) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q          <= '0;
         debug_addr_o  <= '0;
         debug_we_o    <= 1'b0;
         debug_wdata_o <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= cmd_op_i;
         end
         // Bus fields only change when a transaction is about to be issued.
         if (accept && state_d == REQ) begin
            debug_addr_o <= (cmd_op_i == DBGM_READ || cmd_op_i == DBGM_WRITE)
                            ? cmd_addr_i : DBG_ADDR_CTRL;
            debug_we_o   <= (cmd_op_i != DBGM_READ);
            case (cmd_op_i)
               DBGM_HALT:  debug_wdata_o <= DBG_CTRL_HALT;
               DBGM_STEP:  debug_wdata_o <= DBG_CTRL_SSTE;
               DBGM_WRITE: debug_wdata_o <= cmd_wdata_i;
               default:    debug_wdata_o <= '0;
            endcase
         end
         if (rsp_entry) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= rsp_err_d;
            rsp_rdata_o <= (state_q == RVAL && op_q == DBGM_READ && !rsp_err_d)
                           ? debug_rdata_i : '0;
         end else if (state_q == RSP && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
         end
      end
   end

endmodule

// File: doc/riscv_debug_master.md
# riscv_debug_master

Host-side debug initiator for the RI5CY core. It accepts abstract debug commands (halt, resume, single-step, register read, register write) on a valid/ready command port and turns each into transactions on the core's debug bus (req/gnt/rvalid). It then returns one response per command. It sits between an external debug transport (JTAG/UART bridge) and the core's debug unit.

## Interface
- `TIMEOUT`, default 1024: maximum cycles to wait for `debug_gnt_i`, `debug_rvalid_i`, or a halt-state change before the command fails.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_op_i` in 3: command opcode, one of `DBGM_HALT`, `DBGM_RESUME`, `DBGM_STEP`, `DBGM_READ`, `DBGM_WRITE`.
- `cmd_addr_i` in 15: debug address, used by READ and WRITE only.
- `cmd_wdata_i` in 32: write data, used by WRITE only.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed when `rsp_valid_o & rsp_ready_i`.
- `rsp_rdata_o` out 32: read data for READ; 0 for all other commands.
- `rsp_err_o` out 1: the command failed (timeout, illegal opcode, or STEP issued while not halted).
- `debug_req_o` out 1: debug bus request.
- `debug_gnt_i` in 1: request accepted this cycle.
- `debug_rvalid_i` in 1: transaction complete; `debug_rdata_i` is valid.
- `debug_addr_o` out 15: debug bus address.
- `debug_we_o` out 1: 1 for a write, 0 for a read.
- `debug_wdata_o` out 32: debug bus write data.
- `debug_rdata_i` in 32: debug bus read data.
- `debug_halted_i` in 1: the core is in debug halt.

## Operation
- HALT: write `DBG_ADDR_CTRL` = `DBG_CTRL_HALT` (bit 16). Then wait for `debug_halted_i`=1.
- RESUME: write `DBG_ADDR_CTRL` = 0. Then wait for `debug_halted_i`=0.
- STEP:
  - If `debug_halted_i`=0 at acceptance, respond with err=1 and issue no bus transaction.
  - Otherwise write `DBG_ADDR_CTRL` = `DBG_CTRL_SSTE` (bit 0), wait for `debug_halted_i`=0, then wait for `debug_halted_i`=1.
- READ and WRITE: a single bus transaction to `cmd_addr_i`. READ returns the rdata captured on rvalid.
- Any other opcode: respond with err=1 and issue no bus transaction.
- FSM states:
  - IDLE: accept a command, latch op/addr/wdata, go to REQ. Illegal opcode or the STEP-not-halted case goes straight to RSP with err.
  - REQ: hold `debug_req_o`=1 with addr/we/wdata stable until `debug_gnt_i`, then go to RVAL.
  - RVAL: wait for `debug_rvalid_i`. Capture rdata if READ. Go to WAIT_RUN for STEP, WAIT_HALT for HALT, WAIT_RUN for RESUME (the RESUME wait ends when `debug_halted_i`=0), and RSP otherwise.
  - WAIT_RUN: wait for `debug_halted_i`=0. STEP then goes to WAIT_HALT; RESUME goes to RSP.
  - WAIT_HALT: wait for `debug_halted_i`=1, then go to RSP.
  - RSP: hold `rsp_valid_o` and its data stable until `rsp_ready_i`, then go to IDLE.
- Timeout counter:
  - Cleared on every state entry; increments in REQ, RVAL, WAIT_RUN and WAIT_HALT.
  - On reaching `TIMEOUT`-1 without the awaited event, go to RSP with err=1 and drop `debug_req_o`.
  - After a REQ timeout, a late `gnt`/`rvalid` is ignored.
  - The awaited event arriving in the terminal cycle wins over the timeout.
- `debug_rvalid_i` outside RVAL, and `debug_gnt_i` outside REQ, are ignored.

## Timing
- Reset values:
  - `cmd_ready_o`=0 while `rst`=1; it is 1 in IDLE otherwise.
  - `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0.
  - `debug_req_o`=0, `debug_we_o`=0, `debug_addr_o`=0, `debug_wdata_o`=0.
  - FSM in IDLE, timeout counter at 0.
- `cmd_ready_o` and `debug_req_o` are decoded from the registered state. All other outputs are registered.
- Best-case READ/WRITE: accept at cycle 0, `req` at cycle 1 with `gnt` the same cycle, `rvalid` at cycle 2, `rsp_valid_o` at cycle 3.
- `rsp_valid_o` never depends combinationally on `rsp_ready_i`.
- One command is outstanding at a time.
- Back-to-back: `cmd_ready_o` rises the cycle after the response handshake.
- Reset mid-operation returns to IDLE the next cycle. `debug_req_o` drops and the pending response is discarded.

## Structure
- Shared package `riscv_defines` gains:
  - `DBGM_HALT`=3'd0, `DBGM_RESUME`=3'd1, `DBGM_STEP`=3'd2, `DBGM_READ`=3'd3, `DBGM_WRITE`=3'd4.
  - `DBG_ADDR_CTRL`=15'h0000, `DBG_ADDR_NPC`=15'h2000, `DBG_ADDR_PPC`=15'h2004, `DBG_ADDR_GPR0`=15'h0400.
  - `DBG_CTRL_HALT`=32'h0001_0000, `DBG_CTRL_SSTE`=32'h0000_0001.
- The FSM state enum stays local to the module.
- Single module, no sub-module. The timeout counter width is `$clog2(TIMEOUT)`.

## Test plan
- READ `DBG_ADDR_NPC` with `gnt` in the first REQ cycle and `rdata`=32'h1C00_0080 -> `rsp_rdata_o`=32'h1C00_0080, err=0, `rsp_valid_o` at cycle 3.
- WRITE GPR5 (addr 15'h0414, data 32'hDEAD_BEEF) with `gnt` delayed 4 cycles -> addr/we/wdata stable all 5 REQ cycles, `debug_we_o`=1, err=0.
- HALT, then core raises `debug_halted_i` 10 cycles after `rvalid` -> exactly one write of 32'h0001_0000 to addr 0, response err=0.
- STEP while halted:
  - `halted` drops 2 cycles and rises 3 cycles after `rvalid` -> wdata 32'h1, err=0.
  - STEP with `halted`=0 -> no `debug_req_o`, err=1.
- `TIMEOUT`=16, `gnt` never asserted -> `debug_req_o` drops and `rsp_err_o`=1 after 16 REQ cycles; a late `gnt` is ignored.
- `rst` asserted during RVAL -> no response emitted, `cmd_ready_o` returns to 1 after release; opcode 3'd7 -> err=1 with no bus activity.
